fetch_stage: RTL

Instruction-fetch stage of the pipelined MIPS core: it holds the program counter and drives the instruction-memory address. It registers the returned instruction and PC+4 into the IF/ID pipeline register consumed by the decode stage. It applies stall from the hazard unit and redirects from decode (taken beq, j), flushing the wrong-path instruction.

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_stage_if.sv | 45 ++++
 rtl/fetch_stage_pc_reg.sv | 39 +++
 rtl/fetch_stage.sv | 104 ++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants and helpers for the pipelined MIPS core.
// Fetch and decode both import this package.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [5:0]  OP_J   = 6'b000010;
    localparam logic [5:0]  OP_BEQ = 6'b000100;

    // A j keeps the top nibble of the PC+4 of the jump itself
    function automatic logic [31:0] jump_target(input logic [31:0] pc_plus4,
                                                input logic [25:0] index);
        return {pc_plus4[31:28], index, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's memory, redirect/stall and IF/ID signals.
// master = fetch stage side, slave = memory/decode/hazard side.
interface fetch_stage_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [25:0] jump_index;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fetch_misalign;

    modport master (
        output imem_addr,
        input  imem_rdata,
        input  stall,
        input  branch_taken,
        input  branch_target,
        input  jump,
        input  jump_index,
        output if_id_instr,
        output if_id_pc_plus4,
        output if_id_valid,
        output fetch_misalign
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        output stall,
        output branch_taken,
        output branch_target,
        output jump,
        output jump_index,
        input  if_id_instr,
        input  if_id_pc_plus4,
        input  if_id_valid,
        input  fetch_misalign
    );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter register: synchronous reset, load enable and a
// redirect/sequential next-value mux.
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    logic [31:0] pc_d;
    logic [31:0] pc_q;

    // Sequential step wraps naturally mod 2^32
    always_comb begin
        pc_plus4 = pc_q + PC_STEP;
        pc_d     = pc_q;
        if (load_en) begin
            pc_d = redirect ? redirect_pc : pc_plus4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, instruction-memory address and IF/ID register.
// Optional build macro FETCH_ALIGN_CHECK_EN enables misaligned-redirect handling.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic        redirect;
    logic [31:0] raw_target;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    logic [31:0] instr_d;
    logic [31:0] instr_q;
    logic [31:0] pc_plus4_d;
    logic [31:0] pc_plus4_q;
    logic        valid_d;
    logic        valid_q;

    // branch_taken has priority over jump when both fire
    assign redirect   = bus.branch_taken | bus.jump;
    assign raw_target = bus.branch_taken ? bus.branch_target
                                         : jump_target(pc_plus4_q, bus.jump_index);

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_d;
    logic misalign_q;

    assign redirect_pc = raw_target & ~32'h3;

    always_comb begin
        misalign_d = misalign_q;
        if (redirect && (raw_target[1:0] != 2'b00)) begin
            misalign_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign bus.fetch_misalign = misalign_q;
`else
    assign redirect_pc        = raw_target;
    assign bus.fetch_misalign = 1'b0;
`endif

    // Redirect loads the PC even during a stall
    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (clk),
        .reset       (reset),
        .load_en     (redirect | ~bus.stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    // Flush beats stall so the wrong-path slot becomes a bubble
    always_comb begin
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        valid_d    = valid_q;
        if (redirect) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = 32'h0000_0000;
            valid_d    = 1'b0;
        end else if (!bus.stall) begin
            instr_d    = bus.imem_rdata;
            pc_plus4_d = pc_plus4;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= 32'h0000_0000;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign bus.imem_addr      = pc;
    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc_plus4 = pc_plus4_q;
    assign bus.if_id_valid    = valid_q;

endmodule
